konami_bus_decoder: RTL
=======================

// Module: konami_bus_decoder
// PURPOSE
//  Clocked, parametrised successor to the per-board PAL address decoders of the Konami 6809/052526 cores.
//  Decodes the CPU address on the AS strobe into NREG registered active-low chip selects.
//  Holds an internal bank latch; its MSB reroutes banked windows from RAM to program ROM, as BK4 does.
//  Generates per-region wait states through a RDY handshake and flags unmapped accesses.
// PARAMETERS
//  ADDR_W       16          CPU address width
//  NREG         8           number of decoded regions (1..16)
//  BANK_W       5           bank latch width; bit BANK_W-1 is the reroute bit
//  WS_W         3           wait-state counter width
//  REGION_BASE  {NREG*ADDR_W} packed base per region (region i at [i*ADDR_W +: ADDR_W])
//  REGION_MASK  {NREG*ADDR_W} packed compare mask per region (1 = bit compared)
//  REGION_WS    {NREG*WS_W} packed wait-state count per region
//  BANKED       {NREG} bit i=1: region i is a banked window
//  ALT_REG      0           region selected instead of a banked region when BANK[BANK_W-1]=1
//  BANK_ADDR    16'h1F90    bank latch address (full compare; write only)
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       asynchronous active-low reset
//  AS         in   1       CPU address strobe, active low
//  RW         in   1       1 = read, 0 = write
//  A          in   ADDR_W  CPU address
//  DIN        in   8       CPU write data (bank latch source)
//  REGION_EN  in   NREG    per-region enable; 0 = region never matches
//  CS_N       out  NREG    registered chip selects, active low, at most one low
//  BANK       out  BANK_W  bank latch value
//  RDY        out  1       access may complete (registered)
//  DEC_ERR    out  1       current access hit no region (registered)
// BEHAVIOUR
//  Reset (async, immediate, also mid-access): state IDLE, CS_N all 1, BANK 0, RDY 0, DEC_ERR 0, counter 0.
//  All inputs are sampled on the rising edge of clk. All outputs are registered.
//  Match: region i hits when REGION_EN[i] & ((A ^ base_i) & mask_i)==0.
//  Priority: the lowest index that hits wins.
//  Reroute: if the winner has BANKED=1 and BANK[BANK_W-1]=1, the selected region is ALT_REG (its WS applies).
//  FSM:
//  - IDLE: an edge sampling AS=0 decodes A.
//    - Hit with ws=0 -> ACTIVE: CS_N[sel]=0, RDY=1 at that same edge.
//    - Hit with ws>0 -> WAIT: CS_N[sel]=0, RDY=0, cnt=ws-1.
//    - No hit -> ERR: DEC_ERR=1, RDY=1, CS_N all 1.
//  - WAIT: cnt==0 -> ACTIVE, RDY=1; else cnt decrements.
//    RDY therefore first reads 1 after the (1+ws)-th edge from the decode edge.
//  - ACTIVE / ERR: hold outputs while AS=0. A, RW and DIN changes are ignored until AS is released.
//  - Any state with AS sampled 1 -> IDLE next edge: CS_N all 1, RDY 0, DEC_ERR 0.
//    AS released during WAIT aborts the access and no RDY pulse is produced.
//  - A new access needs at least one edge with AS=1 (IDLE). AS held low never re-decodes.
//  Bank latch:
//  - At the decode edge, if RW=0 and A==BANK_ADDR: BANK <= DIN[BANK_W-1:0].
//  - The new value affects only later accesses. The current access is decoded with the old BANK.
//  - BANK_ADDR is also decoded normally. If no region covers it, the access goes to ERR but the latch write still happens.
//  - Reads of BANK_ADDR never change BANK.
//  REGION_EN changes take effect only at the next decode edge; an active CS_N is unaffected.
//  cnt is WS_W bits and never wraps: it stops at 0.
// TESTING
//  1 Reset: assert reset_n=0 mid-WAIT -> CS_N=all 1, RDY=0, BANK=0 immediately, without waiting for a clock.
//  2 Defaults NREG=2: region0 base 0000 mask E000 ws0; region1 base 2000 mask E000 ws3.
//    AS=0, A=2345 -> CS_N=2'b01 at decode edge +1, RDY=1 at edge +4.
//    AS=0, A=0010 -> CS_N=2'b10 and RDY=1 at edge +1.
//  3 Priority/enable: overlapping regions 0 and 1 both hit A=0100 -> region 0 selected.
//    Repeat with REGION_EN[0]=0 -> region 1 selected.
//  4 Bank: write DIN=8'h10 to 1F90 -> BANK=5'h10; then a read in a BANKED region -> CS_N[ALT_REG]=0.
//    Write DIN=8'h03 -> BANK=5'h03 -> the original region is selected again.
//  5 Unmapped: A=FFFF with no region covering it -> DEC_ERR=1, RDY=1, CS_N all 1.
//    AS=1 -> DEC_ERR=0 at the next edge.
//  6 Abort: ws=5 access, AS released after 2 edges -> IDLE, RDY never 1.
//    Back-to-back access with a single AS=1 cycle -> decoded correctly.

Source files
------------

// File: rtl/konami_bus_if.sv
// CPU-side bus of the Konami address decoder: strobe, address, write data and
// region enables in; chip selects, bank latch, ready and decode error out.
interface konami_bus_if #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int BANK_W = 5
);
    logic              AS;
    logic              RW;
    logic [ADDR_W-1:0] A;
    logic [7:0]        DIN;
    logic [NREG-1:0]   REGION_EN;
    logic [NREG-1:0]   CS_N;
    logic [BANK_W-1:0] BANK;
    logic              RDY;
    logic              DEC_ERR;

    modport master (
        output AS, RW, A, DIN, REGION_EN,
        input  CS_N, BANK, RDY, DEC_ERR
    );

    modport slave (
        input  AS, RW, A, DIN, REGION_EN,
        output CS_N, BANK, RDY, DEC_ERR
    );
endinterface

// File: rtl/konami_bus_decoder.sv
// Clocked address decoder: registered active-low chip selects, a bank latch
// whose MSB reroutes banked windows to ALT_REG, per-region wait states and
// an unmapped-access flag.
module konami_bus_decoder #(
    parameter int                     ADDR_W      = 16,
    parameter int                     NREG        = 8,
    parameter int                     BANK_W      = 5,
    parameter int                     WS_W        = 3,
    parameter logic [NREG*ADDR_W-1:0] REGION_BASE = {16'hE000, 16'hC000, 16'hA000, 16'h8000,
                                                     16'h6000, 16'h4000, 16'h2000, 16'h0000},
    parameter logic [NREG*ADDR_W-1:0] REGION_MASK = {8{16'hE000}},
    parameter logic [NREG*WS_W-1:0]   REGION_WS   = {3'd1, 3'd1, 3'd2, 3'd2,
                                                     3'd1, 3'd0, 3'd3, 3'd0},
    parameter logic [NREG-1:0]        BANKED      = 8'b0001_0000,
    parameter int                     ALT_REG     = 0,
    parameter logic [ADDR_W-1:0]      BANK_ADDR   = 16'h1F90
) (
    input  logic         clk,
    input  logic         reset_n,
    konami_bus_if.slave  bus
);

    localparam int SEL_W = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t            r_state;
    logic [NREG-1:0]   r_cs_n;
    logic [BANK_W-1:0] r_bank;
    logic              r_rdy;
    logic              r_dec_err;
    logic [WS_W-1:0]   r_cnt;

    logic [NREG-1:0]   w_hit;
    logic              w_any;
    logic [SEL_W-1:0]  w_win;
    logic [SEL_W-1:0]  w_sel;
    logic [WS_W-1:0]   w_ws;
    logic              w_bank_wr;
    logic [BANK_W-1:0] w_bank_nxt;

    // Per-region masked compare, gated by the live region enable
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NREG; i++)
            w_hit[i] = bus.REGION_EN[i] &&
                       (((bus.A ^ REGION_BASE[i*ADDR_W +: ADDR_W]) &
                         REGION_MASK[i*ADDR_W +: ADDR_W]) == '0);
    end

    // Lowest hitting index wins; a banked winner moves to ALT_REG when the bank MSB is set
    always_comb begin
        w_win = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (w_hit[i]) w_win = SEL_W'(i);
        w_any = |w_hit;
        w_sel = (BANKED[w_win] && r_bank[BANK_W-1]) ? SEL_W'(ALT_REG) : w_win;
        w_ws  = REGION_WS[w_sel*WS_W +: WS_W];
    end

    // Bank latch is write-only at a full address match; the decode above still uses the old value
    assign w_bank_wr  = !bus.RW && (bus.A == BANK_ADDR);
    assign w_bank_nxt = BANK_W'(bus.DIN);

    // Access FSM with registered chip selects, ready and error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cs_n    <= '1;
            r_bank    <= '0;
            r_rdy     <= 1'b0;
            r_dec_err <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.AS) begin
            // strobe released: end or abort whatever was in flight
            r_state   <= IDLE;
            r_cs_n    <= '1;
            r_rdy     <= 1'b0;
            r_dec_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_bank_wr) r_bank <= w_bank_nxt;
                    if (w_any) begin
                        r_cs_n <= ~(NREG'(1) << w_sel);
                        if (w_ws == '0) begin
                            r_state <= ACTIVE;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_rdy   <= 1'b0;
                            r_cnt   <= w_ws - WS_W'(1);
                        end
                    end else begin
                        r_state   <= ERR;
                        r_dec_err <= 1'b1;
                        r_rdy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ACTIVE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - WS_W'(1);
                    end
                end
                default: ; // ACTIVE / ERR hold until AS goes high
            endcase
        end
    end

    assign bus.CS_N    = r_cs_n;
    assign bus.BANK    = r_bank;
    assign bus.RDY     = r_rdy;
    assign bus.DEC_ERR = r_dec_err;

endmodule
